// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction codes, status codes, register ids and
// the control fields the M/W pipeline register loads on reset or bubble.
package y86_pkg;

   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   localparam logic [3:0] SAOK = 4'h1;
   localparam logic [3:0] SHLT = 4'h2;
   localparam logic [3:0] SADR = 4'h3;
   localparam logic [3:0] SINS = 4'h4;

   localparam logic [3:0] RNONE = 4'hF;

   typedef struct packed {
      logic [3:0] stat;
      logic [3:0] icode;
      logic [3:0] dst_e;
      logic [3:0] dst_m;
   } w_ctrl_t;

   localparam w_ctrl_t W_CTRL_NOP = '{stat: SAOK, icode: INOP, dst_e: RNONE, dst_m: RNONE};

   function automatic logic mem_reads(input logic [3:0] icode);
      return (icode == IMRMOVQ) || (icode == IRET) || (icode == IPOPQ);
   endfunction

   function automatic logic mem_writes(input logic [3:0] icode);
      return (icode == IRMMOVQ) || (icode == ICALL) || (icode == IPUSHQ);
   endfunction

endpackage

// File: rtl/y86_mem_stage_if.sv
// Execute-to-writeback bus seen by the memory stage: M-stage inputs, hazard
// controls, forwarding outputs and the registered W-stage fields.
interface y86_mem_stage_if #(
   parameter int DATA_W = 64
);
   logic [3:0]        M_stat;
   logic [3:0]        M_icode;
   logic [DATA_W-1:0] M_valE;
   logic [DATA_W-1:0] M_valA;
   logic [3:0]        M_dstE;
   logic [3:0]        M_dstM;
   logic              W_stall;
   logic              W_bubble;
   logic [DATA_W-1:0] m_valM;
   logic [3:0]        m_stat;
   logic [3:0]        W_stat;
   logic [3:0]        W_icode;
   logic [3:0]        W_dstE;
   logic [3:0]        W_dstM;
   logic [DATA_W-1:0] W_valE;
   logic [DATA_W-1:0] W_valM;
   logic              mem_halted;

   modport master (
      output M_stat, M_icode, M_valE, M_valA, M_dstE, M_dstM, W_stall, W_bubble,
      input  m_valM, m_stat, W_stat, W_icode, W_dstE, W_dstM, W_valE, W_valM, mem_halted
   );

   modport slave (
      input  M_stat, M_icode, M_valE, M_valA, M_dstE, M_dstM, W_stall, W_bubble,
      output m_valM, m_stat, W_stat, W_icode, W_dstE, W_dstM, W_valE, W_valM, mem_halted
   );
endinterface

// File: rtl/y86_dmem.sv
// Word-wide data RAM: asynchronous read port, synchronous write port with enable.
module y86_dmem #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 1024,
   parameter int IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [IDX_W-1:0]  i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [IDX_W-1:0]  i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   // NOTE: the array has no reset branch; clearing a RAM costs a write per word.
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/y86_mem_stage.sv
// Y86-64 memory stage: decode, data-memory access, address check and the M/W
// pipeline register. Y86_MEM_ADDR_CHECK_EN enables range/alignment checking.
module y86_mem_stage
   import y86_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 64,
   parameter int DEPTH  = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   y86_mem_stage_if.slave        bus
);

   localparam int BYTES = DATA_W / 8;
   localparam int OFF_W = $clog2(BYTES);
   localparam int IDX_W = $clog2(DEPTH);

   logic              w_rd;
   logic              w_wr;
   logic              w_addr_bad;
   logic              w_we;
   logic [DATA_W-1:0] w_addr_src;
   logic [ADDR_W-1:0] w_addr;
   logic [IDX_W-1:0]  w_idx;
   logic [3:0]        w_m_stat;
   logic [DATA_W-1:0] w_rdata;

   w_ctrl_t           r_ctrl;
   logic [DATA_W-1:0] r_val_e;
   logic [DATA_W-1:0] r_val_m;
   logic              r_halted;

   // NOTE: every combinational output gets a value on every path, so no latch can form.
   always_comb begin
      w_rd       = mem_reads(bus.M_icode);
      w_wr       = mem_writes(bus.M_icode);
      // Stack pops take their address from the old %rsp carried in valA.
      w_addr_src = ((bus.M_icode == IRET) || (bus.M_icode == IPOPQ)) ? bus.M_valA : bus.M_valE;
      w_addr     = ADDR_W'(w_addr_src);
      w_idx      = IDX_W'(w_addr >> OFF_W);
`ifdef Y86_MEM_ADDR_CHECK_EN
      w_addr_bad = (w_rd || w_wr) &&
                   (((w_addr >> (OFF_W + IDX_W)) != '0) ||
                    ((w_addr & ADDR_W'(BYTES - 1)) != '0));
`else
      w_addr_bad = 1'b0;
`endif
      w_m_stat   = w_addr_bad ? SADR : bus.M_stat;
      w_we       = rst_n && w_wr && (w_m_stat == SAOK) && !bus.W_stall && !r_halted;
   end

   y86_dmem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_dmem (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (w_idx),
      .i_wdata (bus.M_valA),
      .i_raddr (w_idx),
      .o_rdata (w_rdata)
   );

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ctrl   <= W_CTRL_NOP;
         r_val_e  <= '0;
         r_val_m  <= '0;
         r_halted <= 1'b0;
      end else if (bus.W_stall) begin
         r_ctrl   <= r_ctrl;
      end else if (bus.W_bubble) begin
         r_ctrl   <= W_CTRL_NOP;
         r_val_e  <= '0;
         r_val_m  <= '0;
      end else begin
         r_ctrl   <= '{stat: w_m_stat, icode: bus.M_icode, dst_e: bus.M_dstE, dst_m: bus.M_dstM};
         r_val_e  <= bus.M_valE;
         r_val_m  <= bus.m_valM;
         if (w_m_stat != SAOK) r_halted <= 1'b1;
      end
   end

   assign bus.m_valM     = (w_rd && !w_addr_bad) ? w_rdata : '0;
   assign bus.m_stat     = w_m_stat;
   assign bus.W_stat     = r_ctrl.stat;
   assign bus.W_icode    = r_ctrl.icode;
   assign bus.W_dstE     = r_ctrl.dst_e;
   assign bus.W_dstM     = r_ctrl.dst_m;
   assign bus.W_valE     = r_val_e;
   assign bus.W_valM     = r_val_m;
   assign bus.mem_halted = r_halted;

endmodule

// File: tb/tb_y86_mem_stage.sv
// Directed bench for y86_mem_stage: memory ops, stall/bubble, aliasing or
// address checking (Y86_MEM_ADDR_CHECK_EN), reset and the sticky halt.
module tb_y86_mem_stage;
   import y86_pkg::*;

   localparam int DATA_W = 64;
   localparam int ADDR_W = 64;
   localparam int DEPTH  = 1024;

   logic clk = 1'b0;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic [63:0] exp_w2;

   always #5 clk = ~clk;

   y86_mem_stage_if #(.DATA_W(DATA_W)) bus ();

   y86_mem_stage #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance past the next rising edge; outputs are sampled 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] icode, input logic [63:0] val_e, input logic [63:0] val_a,
                        input logic [3:0] dst_e, input logic [3:0] dst_m, input logic [3:0] stat);
      bus.M_icode = icode;
      bus.M_valE  = val_e;
      bus.M_valA  = val_a;
      bus.M_dstE  = dst_e;
      bus.M_dstM  = dst_m;
      bus.M_stat  = stat;
      #1;
   endtask

   task automatic check_w_nop(input string tag);
      check({tag, ".stat"},  64'(bus.W_stat),  64'(SAOK));
      check({tag, ".icode"}, 64'(bus.W_icode), 64'(INOP));
      check({tag, ".dstE"},  64'(bus.W_dstE),  64'(RNONE));
      check({tag, ".dstM"},  64'(bus.W_dstM),  64'(RNONE));
      check({tag, ".valE"},  bus.W_valE,       64'h0);
      check({tag, ".valM"},  bus.W_valM,       64'h0);
   endtask

   initial begin
      rst_n        = 1'b0;
      bus.W_stall  = 1'b0;
      bus.W_bubble = 1'b0;
      drive(INOP, 64'h0, 64'h0, RNONE, RNONE, SAOK);
      tick();
      tick();
      check_w_nop("reset");
      check("reset.halted", 64'(bus.mem_halted), 64'h0);
      rst_n = 1'b1;

      // rmmovq then mrmovq at 0x10
      drive(IRMMOVQ, 64'h10, 64'hDEAD, RNONE, RNONE, SAOK);
      check("rmmov.m_stat", 64'(bus.m_stat), 64'(SAOK));
      check("rmmov.m_valM", bus.m_valM, 64'h0);
      tick();
      check("rmmov.W_icode", 64'(bus.W_icode), 64'(IRMMOVQ));
      check("rmmov.W_valE", bus.W_valE, 64'h10);
      drive(IMRMOVQ, 64'h10, 64'h0, RNONE, 4'h3, SAOK);
      check("mrmov.m_valM", bus.m_valM, 64'hDEAD);
      tick();
      check("mrmov.W_valM", bus.W_valM, 64'hDEAD);
      check("mrmov.W_dstM", 64'(bus.W_dstM), 64'h3);
      exp_w2 = 64'hDEAD;

      // call/ret through 0x1F8
      drive(ICALL, 64'h1F8, 64'h40, 4'h4, RNONE, SAOK);
      tick();
      drive(IRET, 64'h200, 64'h1F8, 4'h4, RNONE, SAOK);
      check("ret.m_valM", bus.m_valM, 64'h40);
      tick();

      // seed 0x1E8, then pushq/popq through 0x1F0
      drive(IRMMOVQ, 64'h1E8, 64'h1111, RNONE, RNONE, SAOK);
      tick();
      drive(IPUSHQ, 64'h1F0, 64'h1234, 4'h4, RNONE, SAOK);
      tick();
      drive(IPOPQ, 64'h1F8, 64'h1F0, 4'h4, 4'h5, SAOK);
      check("pop.m_valM", bus.m_valM, 64'h1234);
      tick();
      check("pop.W_icode", 64'(bus.W_icode), 64'(IPOPQ));

      // stalled pushq: W holds, write waits for release
      bus.W_stall = 1'b1;
      drive(IPUSHQ, 64'h1E8, 64'hBEEF, 4'h4, RNONE, SAOK);
      tick();
      tick();
      check("stall.W_icode", 64'(bus.W_icode), 64'(IPOPQ));
      check("stall.W_valM", bus.W_valM, 64'h1234);
      check("stall.W_valE", bus.W_valE, 64'h1F8);
      drive(IMRMOVQ, 64'h1E8, 64'h0, RNONE, 4'h6, SAOK);
      check("stall.no_write", bus.m_valM, 64'h1111);
      drive(IPUSHQ, 64'h1E8, 64'hBEEF, 4'h4, RNONE, SAOK);
      bus.W_stall = 1'b0;
      tick();
      check("release.W_icode", 64'(bus.W_icode), 64'(IPUSHQ));
      drive(IMRMOVQ, 64'h1E8, 64'h0, RNONE, 4'h6, SAOK);
      check("release.write", bus.m_valM, 64'hBEEF);
      tick();

      // bubble, then stall+bubble together
      bus.W_bubble = 1'b1;
      drive(IMRMOVQ, 64'h10, 64'h0, RNONE, 4'h3, SAOK);
      tick();
      check_w_nop("bubble");
      bus.W_bubble = 1'b0;
      tick();
      check("load.W_valM", bus.W_valM, 64'hDEAD);
      bus.W_stall  = 1'b1;
      bus.W_bubble = 1'b1;
      drive(IPOPQ, 64'h1F8, 64'h1F0, 4'h4, 4'h5, SAOK);
      tick();
      check("both.W_icode", 64'(bus.W_icode), 64'(IMRMOVQ));
      check("both.W_valM", bus.W_valM, 64'hDEAD);
      bus.W_stall  = 1'b0;
      bus.W_bubble = 1'b0;

`ifdef Y86_MEM_ADDR_CHECK_EN
      drive(IRMMOVQ, 64'h2000, 64'h5A5A, RNONE, RNONE, SAOK);
      check("oob.m_stat", 64'(bus.m_stat), 64'(SADR));
      tick();
      check("oob.halted", 64'(bus.mem_halted), 64'h1);
      check("oob.W_stat", 64'(bus.W_stat), 64'(SADR));
      drive(IRMMOVQ, 64'h13, 64'h5A5A, RNONE, RNONE, SAOK);
      check("misalign.m_stat", 64'(bus.m_stat), 64'(SADR));
      drive(IMRMOVQ, 64'h13, 64'h0, RNONE, 4'h3, SAOK);
      check("misalign.m_valM", bus.m_valM, 64'h0);
      drive(IRMMOVQ, 64'h10, 64'h7777, RNONE, RNONE, SAOK);
      tick();
      drive(IMRMOVQ, 64'h10, 64'h0, RNONE, 4'h3, SAOK);
      check("halted.no_write", bus.m_valM, exp_w2);
`else
      drive(IRMMOVQ, 64'h2010, 64'hA5A5, RNONE, RNONE, SAOK);
      check("alias.m_stat", 64'(bus.m_stat), 64'(SAOK));
      tick();
      exp_w2 = 64'hA5A5;
      drive(IMRMOVQ, 64'h10, 64'h0, RNONE, 4'h3, SAOK);
      check("alias.m_valM", bus.m_valM, exp_w2);
`endif

      // reset during a store: write suppressed, W reset, halt cleared
      rst_n = 1'b0;
      drive(IRMMOVQ, 64'h10, 64'hCAFE, RNONE, RNONE, SAOK);
      tick();
      check_w_nop("rst_mid");
      check("rst_mid.halted", 64'(bus.mem_halted), 64'h0);
      rst_n = 1'b1;
      drive(IMRMOVQ, 64'h10, 64'h0, RNONE, 4'h3, SAOK);
      check("rst_mid.no_write", bus.m_valM, exp_w2);
      tick();

      // halt status commits, then later stores are blocked
      drive(IHALT, 64'h0, 64'h0, RNONE, RNONE, SHLT);
      check("halt.m_stat", 64'(bus.m_stat), 64'(SHLT));
      check("halt.pre", 64'(bus.mem_halted), 64'h0);
      tick();
      check("halt.halted", 64'(bus.mem_halted), 64'h1);
      check("halt.W_stat", 64'(bus.W_stat), 64'(SHLT));
      drive(IRMMOVQ, 64'h10, 64'h9999, RNONE, RNONE, SAOK);
      tick();
      check("halt.sticky", 64'(bus.mem_halted), 64'h1);
      drive(IMRMOVQ, 64'h10, 64'h0, RNONE, 4'h3, SAOK);
      check("halt.no_write", bus.m_valM, exp_w2);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
